// File: rtl/sub_top_sys_clk_en_gen.sv
// Multi-channel clock-enable generator on the system reference clock: programmable divide and
// phase per channel, shadowed configuration, and a locked flag after a fixed settling interval.
module sub_top_sys_clk_en_gen #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned LOCK_CYCLES = 1024,
  parameter int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic [NUM_CH-1:0] clk_en,
  output logic [NUM_CH-1:0] clk_sq,
  output logic              locked
);

  localparam int unsigned LockW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StLocking, StLocked} state_e;

  state_e                        state_q, state_d;
  logic [LockW-1:0]              lock_cnt_q, lock_cnt_d;
  logic [NUM_CH-1:0][DIV_W-1:0]  sh_div_q, sh_div_d;
  logic [NUM_CH-1:0][DIV_W-1:0]  sh_phase_q, sh_phase_d;
  logic [NUM_CH-1:0][DIV_W-1:0]  act_div_q, act_div_d;
  logic [NUM_CH-1:0][DIV_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0]             clk_en_q, clk_en_d;
  logic [NUM_CH-1:0]             clk_sq_q, clk_sq_d;
  logic                          cfg_fire;
  logic                          ch_ok;

  function automatic logic [DIV_W-1:0] clamp_phase(input logic [DIV_W-1:0] div,
                                                   input logic [DIV_W-1:0] phase);
    if (div == '0) begin
      return '0;
    end else if (phase >= div) begin
      return div - DIV_W'(1);
    end
    return phase;
  endfunction

  // High for the first ceil(div/2) counts of each period.
  function automatic logic sq_high(input logic [DIV_W-1:0] div, input logic [DIV_W-1:0] cnt);
    logic [DIV_W:0] half;
    half = ({1'b0, div} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
    return {1'b0, cnt} < half;
  endfunction

  assign cfg_ready = (state_q != StLocking);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign ch_ok     = int'(cfg_ch) < int'(NUM_CH);

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    sh_div_d   = sh_div_q;
    sh_phase_d = sh_phase_q;
    act_div_d  = act_div_q;
    cnt_d      = cnt_q;
    clk_en_d   = '0;
    clk_sq_d   = '0;

    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (cfg_fire && ch_ok && int'(cfg_ch) == c) begin
        sh_div_d[c]   = cfg_div;
        sh_phase_d[c] = clamp_phase(cfg_div, cfg_phase);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (run) begin
          state_d    = StLocking;
          lock_cnt_d = '0;
        end
      end
      StLocking: begin
        if (!run) begin
          state_d = StIdle;
        end else if (lock_cnt_q == LockW'(LOCK_CYCLES - 1)) begin
          state_d   = StLocked;
          act_div_d = sh_div_q;
          // Preload so a channel with phase p reaches zero p cycles after lock.
          for (int c = 0; c < int'(NUM_CH); c++) begin
            cnt_d[c] = (sh_phase_q[c] == '0) ? '0 : sh_div_q[c] - sh_phase_q[c];
          end
        end else begin
          lock_cnt_d = lock_cnt_q + LockW'(1);
        end
      end
      StLocked: begin
        if (!run) begin
          state_d = StIdle;
        end else if (cfg_fire && ch_ok) begin
          state_d    = StLocking;
          lock_cnt_d = '0;
        end else begin
          for (int c = 0; c < int'(NUM_CH); c++) begin
            if (act_div_q[c] != '0) begin
              cnt_d[c] = (cnt_q[c] == act_div_q[c] - DIV_W'(1)) ? '0 : cnt_q[c] + DIV_W'(1);
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered from next-state so they line up with locked.
    if (state_d == StLocked) begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (act_div_d[c] != '0) begin
          clk_en_d[c] = (cnt_d[c] == '0);
          clk_sq_d[c] = sq_high(act_div_d[c], cnt_d[c]);
        end
      end
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      lock_cnt_q <= '0;
      sh_div_q   <= '0;
      sh_phase_q <= '0;
      act_div_q  <= '0;
      cnt_q      <= '0;
      clk_en_q   <= '0;
      clk_sq_q   <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      sh_div_q   <= sh_div_d;
      sh_phase_q <= sh_phase_d;
      act_div_q  <= act_div_d;
      cnt_q      <= cnt_d;
      clk_en_q   <= clk_en_d;
      clk_sq_q   <= clk_sq_d;
    end
  end

  assign locked = (state_q == StLocked);
  assign clk_en = clk_en_q;
  assign clk_sq = clk_sq_q;

endmodule

// File: tb/tb_sub_top_sys_clk_en_gen.sv
// Directed bench for sub_top_sys_clk_en_gen: expected output vectors are queued as stimulus is
// driven and compared each cycle on the falling edge.
module tb_sub_top_sys_clk_en_gen;

  localparam int NCH  = 4;
  localparam int DW   = 16;
  localparam int LOCK = 16;
  localparam int CW   = 3;

  logic           refclk;
  logic           rst_n;
  logic           run;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [CW-1:0]  cfg_ch;
  logic [DW-1:0]  cfg_div;
  logic [DW-1:0]  cfg_phase;
  logic [NCH-1:0] clk_en;
  logic [NCH-1:0] clk_sq;
  logic           locked;

  sub_top_sys_clk_en_gen #(
    .NUM_CH      (NCH),
    .DIV_W       (DW),
    .LOCK_CYCLES (LOCK),
    .CH_W        (CW)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .run       (run),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_phase (cfg_phase),
    .clk_en    (clk_en),
    .clk_sq    (clk_sq),
    .locked    (locked)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  typedef struct packed {
    logic           lck;
    logic           rdy;
    logic [NCH-1:0] en;
    logic [NCH-1:0] sq;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   m_div[NCH];
  int   m_phase[NCH];
  int   lk;

  task automatic clear_model();
    for (int c = 0; c < NCH; c++) begin
      m_div[c]   = 0;
      m_phase[c] = 0;
    end
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) sb.push_back('{lck: 1'b0, rdy: 1'b1, en: '0, sq: '0});
  endtask

  task automatic push_locking(input int n);
    for (int i = 0; i < n; i++) sb.push_back('{lck: 1'b0, rdy: 1'b0, en: '0, sq: '0});
  endtask

  // Channel position r = (p' + k) mod d where p' = d - p; enable at r==0, square high r < ceil(d/2).
  task automatic push_locked(input int n);
    exp_t e;
    int   r;
    for (int i = 0; i < n; i++) begin
      e = '{lck: 1'b1, rdy: 1'b1, en: '0, sq: '0};
      for (int c = 0; c < NCH; c++) begin
        if (m_div[c] != 0) begin
          r       = (m_div[c] - m_phase[c] + lk) % m_div[c];
          e.en[c] = (r == 0);
          e.sq[c] = (r < (m_div[c] + 1) / 2);
        end
      end
      sb.push_back(e);
      lk++;
    end
  endtask

  task automatic cfg_write(input int ch, input int div, input int ph);
    cfg_valid = 1'b1;
    cfg_ch    = CW'(ch);
    cfg_div   = DW'(div);
    cfg_phase = DW'(ph);
    if (ch < NCH) begin
      m_div[ch]   = div;
      m_phase[ch] = (div == 0) ? 0 : ((ph >= div) ? div - 1 : ph);
    end
  endtask

  task automatic check_now(input string tag);
    exp_t e;
    exp_t got;
    checks++;
    got = '{lck: locked, rdy: cfg_ready, en: clk_en, sq: clk_sq};
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL %s: scoreboard empty, got locked=%b ready=%b en=%b sq=%b", tag, locked,
             cfg_ready, clk_en, clk_sq);
    end else begin
      e = sb.pop_front();
      assert (got === e) else begin
        failures++;
        $error("FAIL %s @%0t: got locked=%b ready=%b en=%b sq=%b, expected locked=%b ready=%b en=%b sq=%b",
               tag, $time, got.lck, got.rdy, got.en, got.sq, e.lck, e.rdy, e.en, e.sq);
      end
    end
  endtask

  task automatic tick(input string tag);
    @(posedge refclk);
    @(negedge refclk);
    check_now(tag);
  endtask

  task automatic cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    run       = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
    cfg_phase = '0;
    lk        = 0;
    clear_model();

    @(negedge refclk);
    push_idle(1);
    check_now("reset");
    rst_n = 1'b1;
    push_idle(1);
    tick("idle_hold");

    // No configuration: lock after 16 cycles, every channel disabled.
    run = 1'b1;
    push_locking(LOCK);
    lk = 0;
    push_locked(6);
    cycles(LOCK + 6, "s1_lock");

    // Configure in IDLE, including a phase that must clamp.
    run = 1'b0;
    push_idle(1);
    tick("s2_stop");
    cfg_write(0, 4, 0);
    push_idle(1);
    tick("s2_wr_ch0");
    cfg_write(1, 4, 1);
    push_idle(1);
    tick("s2_wr_ch1");
    cfg_write(2, 5, 7);
    push_idle(1);
    tick("s3_wr_ch2");
    cfg_valid = 1'b0;
    run       = 1'b1;
    push_locking(LOCK);
    lk = 0;
    push_locked(12);
    cycles(LOCK + 12, "s2_run");

    // Write while locked forces a full relock.
    cfg_write(3, 1, 0);
    push_locking(1);
    tick("s4_wr");
    cfg_valid = 1'b0;
    push_locking(LOCK - 1);
    lk = 0;
    push_locked(10);
    cycles(LOCK - 1 + 10, "s4_relock");

    // Out-of-range channel: accepted and dropped, no relock.
    cfg_write(5, 2, 0);
    push_locked(1);
    tick("s5_badch");
    cfg_valid = 1'b0;
    push_locked(3);
    cycles(3, "s5_after_badch");

    // Stop and write in the same cycle: IDLE wins, write kept.
    cfg_write(0, 2, 0);
    run = 1'b0;
    push_idle(1);
    tick("s5_idle_wins");
    cfg_valid = 1'b0;
    run       = 1'b1;
    push_locking(LOCK);
    lk = 0;
    push_locked(8);
    cycles(LOCK + 8, "s5_rerun");

    // Asynchronous reset mid-cycle clears state and configuration.
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    push_idle(1);
    check_now("s6_async_rst");
    @(negedge refclk);
    rst_n = 1'b1;
    push_locking(LOCK);
    lk = 0;
    push_locked(4);
    cycles(LOCK + 4, "s6_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
